sram_rmw: RTL and testbench
===========================

# sram_rmw

Dual-port, parametrised on-chip SRAM for the accelerator's processing-element and cache storage. It generalises the plain dual-port RAM wrapper in three ways: words are N_ELEM elements wide, each port can write a whole block or a single element, and each port can accumulate into one element with a two-cycle read-modify-write (RMW) pipeline. Hazard forwarding between the two ports is built in, so the element-accumulate path used for weight and bias updates needs no external stall logic.

## Interface
- WIDTH_ELEM, 32: element width in bits.
- N_ELEM, 4: elements per block; block width is W = WIDTH_ELEM*N_ELEM.
- LG_N_ELEM, 2: log2(N_ELEM).
- DEPTH, 64: blocks in the array.
- LG_DEPTH, 6: log2(DEPTH).
- INIT_VAL, '0: array initial contents (simulation/FPGA init only).
- clk  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high.
- io_addr_p  input  LG_DEPTH  block address, p ∈ {0,1}.
- io_din_p  input  W  block write data.
- io_dinElem_p  input  WIDTH_ELEM  element write/accumulate operand.
- io_idx_p  input  LG_N_ELEM  element index; element 0 is bits [WIDTH_ELEM-1:0].
- io_we_p  input  1  write request.
- io_wType_p  input  2  write type: 0 block write, 1 element write, 2 element accumulate, 3 reserved (treated as 0).
- io_ready_p  output  1  port accepts a request this cycle.
- io_dout_p  output  W  read data.

## Operation
- A request on port p is accepted when io_ready_p is 1. A read is performed on every accepted cycle, whether or not io_we_p is set.
- Block write (wType 0): the array is written with io_din_p at the accept edge. The port stays ready.
- Element write and accumulate (wType 1/2) use a two-stage RMW:
  - Stage R (accept cycle): the block is read; addr, idx, operand and type are latched.
  - Stage M (next cycle): the selected element is replaced (wType 1) or summed with the operand (wType 2). The merged block is written at the end of M.
  - io_ready_p is 0 during M. Inputs are ignored while the port is not ready.
- Accumulate arithmetic: two's complement, WIDTH_ELEM bits, wraps modulo 2^WIDTH_ELEM with no saturation. Unselected elements pass through unchanged.
- Forwarding: the M-stage merge uses the most recent data for its address:
  - A write by the other port to the same address in stage R or stage M is merged before the element op.
  - When both ports are in M on the same address, port 1 merges on top of port 0's merged block, and port 1's result is written.
- Write collision: if both ports write the same address at the same edge and forwarding does not apply, port 0 wins.
- Read-during-write: a read of an address being written at the same edge by either port returns the new data (write-first).
- Reset:
  - io_dout_p is 0 and io_ready_p is 1 in the cycle after reset.
  - Any pending M-stage write is dropped.
  - Array contents are not cleared.

## Timing
- Read latency: 1 cycle. io_dout_p is valid in the cycle after accept and holds until the next accepted request.
- Block write: visible to a read accepted on the following cycle on either port. Same-edge reads see it too, because reads are write-first.
- RMW:
  - Accept at cycle t; the array is updated at the end of t+1.
  - io_ready_p is low in t+1 and high again in t+2.
  - Sustained throughput is one RMW per 2 cycles per port.
- io_dout_p in t+1 of an RMW returns the pre-merge block. The merged block is visible to reads accepted in t+2, or in t+1 on the other port via forwarding.
- reset asserted in t+1 of an RMW suppresses that write.

## Structure
- Shared package `sram_rmw_pkg`:
  - wType encodings (WT_BLOCK, WT_ELEM, WT_ACC).
  - A function computing the element merge (select, replace or add).
- Storage: instantiate the existing dual-port `ram_infer` with WIDTH=W and both clocks tied to clk.
- All RMW stage registers, forwarding comparators and muxes live in this module, around `ram_infer`.

## Test plan
Bench configuration: WIDTH_ELEM=8, N_ELEM=4, DEPTH=16.
- Block write then read: port 0 writes addr 3 = 0x44332211; port 1 reads addr 3 next cycle → io_dout_1 = 0x44332211.
- Element write: block 0x44332211 at addr 3; port 0 wType 1, idx 2, operand 0xAA → io_ready_0 low for 1 cycle; later read gives 0x44AA2211.
- Accumulate with wrap: element 0 = 0xFF; port 1 wType 2, idx 0, operand 0x02 → element 0 = 0x01, other elements unchanged.
- Concurrent accumulate on the same address: both ports wType 2, addr 5 (initially 0), port 0 idx 1 operand 3, port 1 idx 1 operand 4, same cycle → addr 5 element 1 = 7.
- Forwarding from a block write: port 0 accumulates idx 0 operand 1 at addr 7 in cycle t; port 1 block-writes addr 7 = 0x00000010 in cycle t → final 0x00000011.
- Reset mid-RMW: assert reset in the M cycle of an element write → addr unchanged; io_ready 1 and io_dout 0 after reset.

Source files
------------

// File: rtl/sram_rmw_pkg.sv
// Shared definitions for sram_rmw: write-type encodings and the element merge
// used by the read-modify-write stage.
package sram_rmw_pkg;

    typedef enum logic [1:0] {
        WT_BLOCK = 2'd0,
        WT_ELEM  = 2'd1,
        WT_ACC   = 2'd2
    } wtype_e;

    // Upper bounds for the merge function; block and element widths must fit.
    localparam int MAX_BLOCK_W = 1024;
    localparam int MAX_ELEM_W  = 64;

    // The reserved encoding behaves as a plain block write.
    function automatic wtype_e decode_wtype(input logic [1:0] raw);
        case (raw)
            2'd1:    decode_wtype = WT_ELEM;
            2'd2:    decode_wtype = WT_ACC;
            default: decode_wtype = WT_BLOCK;
        endcase
    endfunction

    function automatic logic [MAX_BLOCK_W-1:0] elem_merge(
        input logic [MAX_BLOCK_W-1:0] blk,
        input int unsigned            idx,
        input logic [MAX_ELEM_W-1:0]  operand,
        input wtype_e                 wt,
        input int unsigned            elem_w
    );
        logic [MAX_ELEM_W-1:0] mask;
        logic [MAX_ELEM_W-1:0] cur;
        logic [MAX_ELEM_W-1:0] res;
        int unsigned           lsb;
        lsb  = idx * elem_w;
        // A full-width shift wraps to zero, so the subtraction still gives all ones.
        mask = (MAX_ELEM_W'(1) << elem_w) - MAX_ELEM_W'(1);
        cur  = MAX_ELEM_W'(blk >> lsb) & mask;
        res  = ((wt == WT_ACC) ? (cur + operand) : operand) & mask;
        elem_merge = (blk & ~(MAX_BLOCK_W'(mask) << lsb)) | (MAX_BLOCK_W'(res) << lsb);
    endfunction

endpackage

// File: rtl/ram_infer.sv
// Inferable dual-port RAM with registered, enable-gated, read-first outputs.
module ram_infer #(
    parameter int              WIDTH    = 32,
    parameter int              DEPTH    = 64,
    parameter int              LG_DEPTH = 6,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic                clka,
    input  logic                clkb,
    input  logic                ena,
    input  logic                enb,
    input  logic                wea,
    input  logic                web,
    input  logic [LG_DEPTH-1:0] addra,
    input  logic [LG_DEPTH-1:0] addrb,
    input  logic [WIDTH-1:0]    dina,
    input  logic [WIDTH-1:0]    dinb,
    output logic [WIDTH-1:0]    douta,
    output logic [WIDTH-1:0]    doutb
);

    logic [WIDTH-1:0] mem [DEPTH] = '{default: INIT_VAL};

    // Both write ports commit on clka so the array has a single driver; the
    // users of this RAM tie clka and clkb together. Port a wins a collision.
    always_ff @(posedge clka) begin
        if (web) mem[addrb] <= dinb;
        if (wea) mem[addra] <= dina;
        if (ena) douta <= mem[addra];
    end

    always_ff @(posedge clkb) begin
        if (enb) doutb <= mem[addrb];
    end

endmodule

// File: rtl/sram_rmw.sv
// Dual-port element-addressable SRAM with a two-cycle read-modify-write path
// and cross-port forwarding, built around ram_infer.
module sram_rmw
    import sram_rmw_pkg::*;
#(
    parameter int WIDTH_ELEM = 32,
    parameter int N_ELEM     = 4,
    parameter int LG_N_ELEM  = 2,
    parameter int DEPTH      = 64,
    parameter int LG_DEPTH   = 6,
    parameter logic [WIDTH_ELEM*N_ELEM-1:0] INIT_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [LG_DEPTH-1:0]          io_addr_0,
    input  logic [WIDTH_ELEM*N_ELEM-1:0] io_din_0,
    input  logic [WIDTH_ELEM-1:0]        io_dinElem_0,
    input  logic [LG_N_ELEM-1:0]         io_idx_0,
    input  logic                         io_we_0,
    input  logic [1:0]                   io_wType_0,
    output logic                         io_ready_0,
    output logic [WIDTH_ELEM*N_ELEM-1:0] io_dout_0,
    input  logic [LG_DEPTH-1:0]          io_addr_1,
    input  logic [WIDTH_ELEM*N_ELEM-1:0] io_din_1,
    input  logic [WIDTH_ELEM-1:0]        io_dinElem_1,
    input  logic [LG_N_ELEM-1:0]         io_idx_1,
    input  logic                         io_we_1,
    input  logic [1:0]                   io_wType_1,
    output logic                         io_ready_1,
    output logic [WIDTH_ELEM*N_ELEM-1:0] io_dout_1
);

    localparam int W = WIDTH_ELEM * N_ELEM;

    logic [LG_DEPTH-1:0]   addr     [2];
    logic [W-1:0]          din      [2];
    logic [WIDTH_ELEM-1:0] din_elem [2];
    logic [LG_N_ELEM-1:0]  idx      [2];
    logic                  we       [2];
    logic [1:0]            wtype_in [2];

    logic                  m_valid  [2];
    logic [LG_DEPTH-1:0]   m_addr   [2];
    logic [LG_N_ELEM-1:0]  m_idx    [2];
    logic [WIDTH_ELEM-1:0] m_op     [2];
    wtype_e                m_type   [2];
    logic                  rd_hit   [2];
    logic [W-1:0]          rd_fwd   [2];
    logic                  dout_zero[2];
    logic [W-1:0]          ram_q    [2];

    logic                  ready    [2];
    wtype_e                wt       [2];
    logic                  blk_wr   [2];
    logic                  rmw_start[2];
    logic [W-1:0]          rd_val   [2];
    logic [W-1:0]          base     [2];
    logic [W-1:0]          merged   [2];
    logic                  wen      [2];
    logic [LG_DEPTH-1:0]   wa       [2];
    logic [W-1:0]          wd       [2];
    logic                  byp_hit  [2];
    logic [W-1:0]          byp_data [2];
    logic                  same_wa;

    assign addr     = '{io_addr_0, io_addr_1};
    assign din      = '{io_din_0, io_din_1};
    assign din_elem = '{io_dinElem_0, io_dinElem_1};
    assign idx      = '{io_idx_0, io_idx_1};
    assign we       = '{io_we_0, io_we_1};
    assign wtype_in = '{io_wType_0, io_wType_1};

    always_comb begin
        same_wa = 1'b0;
        for (int p = 0; p < 2; p++) begin
            ready[p]     = ~m_valid[p];
            wt[p]        = decode_wtype(wtype_in[p]);
            blk_wr[p]    = ready[p] & we[p] & (wt[p] == WT_BLOCK);
            rmw_start[p] = ready[p] & we[p] & (wt[p] != WT_BLOCK);
            rd_val[p]    = rd_hit[p] ? rd_fwd[p] : ram_q[p];
            base[p]      = rd_val[p];
            merged[p]    = '0;
            wen[p]       = 1'b0;
            wa[p]        = '0;
            wd[p]        = '0;
            byp_hit[p]   = 1'b0;
            byp_data[p]  = '0;
        end

        // Port 1 merges on top of port 0, so port 0 forwards only block writes.
        if (blk_wr[1] && addr[1] == m_addr[0]) base[0] = din[1];
        merged[0] = W'(elem_merge(MAX_BLOCK_W'(base[0]), int'(m_idx[0]),
                                  MAX_ELEM_W'(m_op[0]), m_type[0], WIDTH_ELEM));
        if (blk_wr[0] && addr[0] == m_addr[1])
            base[1] = din[0];
        else if (m_valid[0] && m_addr[0] == m_addr[1])
            base[1] = merged[0];
        merged[1] = W'(elem_merge(MAX_BLOCK_W'(base[1]), int'(m_idx[1]),
                                  MAX_ELEM_W'(m_op[1]), m_type[1], WIDTH_ELEM));

        for (int p = 0; p < 2; p++) begin
            wen[p] = (m_valid[p] & ~reset) | blk_wr[p];
            wa[p]  = m_valid[p] ? m_addr[p] : addr[p];
            wd[p]  = m_valid[p] ? merged[p] : din[p];
        end

        // A forwarding M-stage write beats the other port; otherwise port 0 wins.
        same_wa = wen[0] & wen[1] & (wa[0] == wa[1]);
        wen[0]  = wen[0] & ~(same_wa & m_valid[1]);
        wen[1]  = wen[1] & ~(same_wa & ~m_valid[1]);

        for (int p = 0; p < 2; p++) begin
            if (wen[0] && wa[0] == addr[p]) begin
                byp_hit[p]  = 1'b1;
                byp_data[p] = wd[0];
            end else if (wen[1] && wa[1] == addr[p]) begin
                byp_hit[p]  = 1'b1;
                byp_data[p] = wd[1];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (reset) begin
                m_valid[p]   <= 1'b0;
                rd_hit[p]    <= 1'b0;
                dout_zero[p] <= 1'b1;
            end else begin
                m_valid[p] <= rmw_start[p];
                if (ready[p]) begin
                    rd_hit[p]    <= byp_hit[p];
                    rd_fwd[p]    <= byp_data[p];
                    dout_zero[p] <= 1'b0;
                end
                if (rmw_start[p]) begin
                    m_addr[p] <= addr[p];
                    m_idx[p]  <= idx[p];
                    m_op[p]   <= din_elem[p];
                    m_type[p] <= wt[p];
                end
            end
        end
    end

    assign io_ready_0 = ready[0];
    assign io_ready_1 = ready[1];
    assign io_dout_0  = dout_zero[0] ? '0 : rd_val[0];
    assign io_dout_1  = dout_zero[1] ? '0 : rd_val[1];

    ram_infer #(
        .WIDTH    (W),
        .DEPTH    (DEPTH),
        .LG_DEPTH (LG_DEPTH),
        .INIT_VAL (INIT_VAL)
    ) u_ram (
        .clka  (clk),
        .clkb  (clk),
        .ena   (ready[0]),
        .enb   (ready[1]),
        .wea   (wen[0]),
        .web   (wen[1]),
        .addra (wen[0] ? wa[0] : addr[0]),
        .addrb (wen[1] ? wa[1] : addr[1]),
        .dina  (wd[0]),
        .dinb  (wd[1]),
        .douta (ram_q[0]),
        .doutb (ram_q[1])
    );

endmodule

// File: tb/tb_sram_rmw.sv
// Directed bench for sram_rmw: block/element writes, accumulate wrap,
// cross-port forwarding and reset during an RMW.
module tb_sram_rmw;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  io_addr_0, io_addr_1;
    logic [31:0] io_din_0, io_din_1;
    logic [7:0]  io_dinElem_0, io_dinElem_1;
    logic [1:0]  io_idx_0, io_idx_1;
    logic        io_we_0, io_we_1;
    logic [1:0]  io_wType_0, io_wType_1;
    logic        io_ready_0, io_ready_1;
    logic [31:0] io_dout_0, io_dout_1;

    int compared   = 0;
    int mismatched = 0;

    sram_rmw #(
        .WIDTH_ELEM (8),
        .N_ELEM     (4),
        .LG_N_ELEM  (2),
        .DEPTH      (16),
        .LG_DEPTH   (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .io_addr_0    (io_addr_0),
        .io_din_0     (io_din_0),
        .io_dinElem_0 (io_dinElem_0),
        .io_idx_0     (io_idx_0),
        .io_we_0      (io_we_0),
        .io_wType_0   (io_wType_0),
        .io_ready_0   (io_ready_0),
        .io_dout_0    (io_dout_0),
        .io_addr_1    (io_addr_1),
        .io_din_1     (io_din_1),
        .io_dinElem_1 (io_dinElem_1),
        .io_idx_1     (io_idx_1),
        .io_we_1      (io_we_1),
        .io_wType_1   (io_wType_1),
        .io_ready_1   (io_ready_1),
        .io_dout_1    (io_dout_1)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int port, input logic we, input logic [1:0] wt,
                                 input logic [3:0] addr, input logic [31:0] din,
                                 input logic [7:0] elem, input logic [1:0] idx);
        if (port == 0) begin
            io_we_0 = we; io_wType_0 = wt; io_addr_0 = addr;
            io_din_0 = din; io_dinElem_0 = elem; io_idx_0 = idx;
        end else begin
            io_we_1 = we; io_wType_1 = wt; io_addr_1 = addr;
            io_din_1 = din; io_dinElem_1 = elem; io_idx_1 = idx;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(0, 1'b0, 2'd0, 4'd0, 32'h0, 8'h0, 2'd0);
        applyStimulus(1, 1'b0, 2'd0, 4'd0, 32'h0, 8'h0, 2'd0);
        tick();
        tick();
        reset = 1'b0;
        checkOutput("rst_ready0", 32'(io_ready_0), 32'd1);
        checkOutput("rst_ready1", 32'(io_ready_1), 32'd1);
        checkOutput("rst_dout0", io_dout_0, 32'h0);
        checkOutput("rst_dout1", io_dout_1, 32'h0);

        // Block write on port 0 with a same-edge read on port 1.
        applyStimulus(0, 1'b1, 2'd0, 4'd3, 32'h44332211, 8'h0, 2'd0);
        applyStimulus(1, 1'b0, 2'd0, 4'd3, 32'h0, 8'h0, 2'd0);
        tick();
        checkOutput("blk_ready0", 32'(io_ready_0), 32'd1);
        checkOutput("blk_same_edge_dout1", io_dout_1, 32'h44332211);
        applyStimulus(0, 1'b0, 2'd0, 4'd3, 32'h0, 8'h0, 2'd0);
        tick();
        checkOutput("blk_next_dout0", io_dout_0, 32'h44332211);
        checkOutput("blk_next_dout1", io_dout_1, 32'h44332211);

        // Element write; the block write attempted during M must be ignored.
        applyStimulus(0, 1'b1, 2'd1, 4'd3, 32'h0, 8'hAA, 2'd2);
        applyStimulus(1, 1'b0, 2'd0, 4'd0, 32'h0, 8'h0, 2'd0);
        tick();
        checkOutput("elem_ready0_low", 32'(io_ready_0), 32'd0);
        checkOutput("elem_premerge_dout0", io_dout_0, 32'h44332211);
        applyStimulus(0, 1'b1, 2'd0, 4'd3, 32'hDEADBEEF, 8'h0, 2'd0);
        applyStimulus(1, 1'b0, 2'd0, 4'd3, 32'h0, 8'h0, 2'd0);
        tick();
        checkOutput("elem_ready0_high", 32'(io_ready_0), 32'd1);
        checkOutput("elem_fwd_dout1", io_dout_1, 32'h44AA2211);
        checkOutput("elem_hold_dout0", io_dout_0, 32'h44332211);
        applyStimulus(0, 1'b0, 2'd0, 4'd3, 32'h0, 8'h0, 2'd0);
        tick();
        checkOutput("elem_final_dout0", io_dout_0, 32'h44AA2211);

        // Accumulate with wrap on port 1: 0xFF + 0x02 = 0x01.
        applyStimulus(0, 1'b1, 2'd0, 4'd9, 32'h123456FF, 8'h0, 2'd0);
        tick();
        applyStimulus(0, 1'b0, 2'd0, 4'd0, 32'h0, 8'h0, 2'd0);
        applyStimulus(1, 1'b1, 2'd2, 4'd9, 32'h0, 8'h02, 2'd0);
        tick();
        checkOutput("acc_ready1_low", 32'(io_ready_1), 32'd0);
        applyStimulus(1, 1'b0, 2'd0, 4'd0, 32'h0, 8'h0, 2'd0);
        tick();
        checkOutput("acc_ready1_high", 32'(io_ready_1), 32'd1);
        applyStimulus(0, 1'b0, 2'd0, 4'd9, 32'h0, 8'h0, 2'd0);
        tick();
        checkOutput("acc_wrap_dout0", io_dout_0, 32'h12345601);

        // Both ports accumulate into the same element in the same cycle.
        applyStimulus(0, 1'b1, 2'd2, 4'd5, 32'h0, 8'h03, 2'd1);
        applyStimulus(1, 1'b1, 2'd2, 4'd5, 32'h0, 8'h04, 2'd1);
        tick();
        checkOutput("dual_ready0_low", 32'(io_ready_0), 32'd0);
        checkOutput("dual_ready1_low", 32'(io_ready_1), 32'd0);
        applyStimulus(0, 1'b0, 2'd0, 4'd0, 32'h0, 8'h0, 2'd0);
        applyStimulus(1, 1'b0, 2'd0, 4'd0, 32'h0, 8'h0, 2'd0);
        tick();
        applyStimulus(0, 1'b0, 2'd0, 4'd5, 32'h0, 8'h0, 2'd0);
        tick();
        checkOutput("dual_acc_dout0", io_dout_0, 32'h00000700);

        // Block write in the accumulate's R cycle.
        applyStimulus(0, 1'b1, 2'd2, 4'd7, 32'h0, 8'h01, 2'd0);
        applyStimulus(1, 1'b1, 2'd0, 4'd7, 32'h00000010, 8'h0, 2'd0);
        tick();
        applyStimulus(0, 1'b0, 2'd0, 4'd0, 32'h0, 8'h0, 2'd0);
        applyStimulus(1, 1'b0, 2'd0, 4'd0, 32'h0, 8'h0, 2'd0);
        tick();
        applyStimulus(1, 1'b0, 2'd0, 4'd7, 32'h0, 8'h0, 2'd0);
        tick();
        checkOutput("fwd_r_dout1", io_dout_1, 32'h00000011);

        // Block write (reserved type 3) in the accumulate's M cycle.
        applyStimulus(0, 1'b1, 2'd2, 4'd8, 32'h0, 8'h01, 2'd0);
        tick();
        applyStimulus(0, 1'b0, 2'd0, 4'd0, 32'h0, 8'h0, 2'd0);
        applyStimulus(1, 1'b1, 2'd3, 4'd8, 32'h00000020, 8'h0, 2'd0);
        tick();
        applyStimulus(1, 1'b0, 2'd0, 4'd8, 32'h0, 8'h0, 2'd0);
        tick();
        checkOutput("fwd_m_dout1", io_dout_1, 32'h00000021);

        // Reset during the M cycle of an element write drops the write.
        applyStimulus(1, 1'b1, 2'd1, 4'd3, 32'h0, 8'h55, 2'd3);
        tick();
        checkOutput("rstm_pre_dout1", io_dout_1, 32'h44AA2211);
        applyStimulus(1, 1'b0, 2'd0, 4'd3, 32'h0, 8'h0, 2'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rstm_ready1", 32'(io_ready_1), 32'd1);
        checkOutput("rstm_dout1", io_dout_1, 32'h0);
        checkOutput("rstm_dout0", io_dout_0, 32'h0);
        applyStimulus(0, 1'b0, 2'd0, 4'd3, 32'h0, 8'h0, 2'd0);
        tick();
        checkOutput("rstm_addr_unchanged", io_dout_0, 32'h44AA2211);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
